tpu_reg_master: RTL and testbench
=================================

Name: tpu_reg_master

Overview:
- Register-bus initiator for the TPU register file. It drives addr / data_in / we and consumes data_out and TPUINT.
- Accepts write/read commands from a host through a valid/ready port and buffers them in a small command FIFO.
- Executes commands one at a time on the register bus and returns read data through a response pulse.
- Optionally services TPUINT on its own: a rising edge triggers a flag-clear write that takes priority over queued commands.
- Sits between the host-side logic and the tpu top-level in the SYS_CLK domain.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16
RD_LATENCY, 1, extra clocks between bus_addr driven and bus_rdata valid; 0..3
IRQ_AUTOCLR, 1, 1 = auto-issue the INTFLAG clear write on a TPUINT rising edge; 0 = count only
INTFLAG_ADDR, 8'h02, register address written by the auto-clear
INTCLR_VALUE, 8'h00, data written by the auto-clear

Ports:
SYS_CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full; handshake completes when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  8  register address
cmd_wdata  in  8  write data; ignored for reads
rsp_valid  out  1  one-cycle pulse; read data available
rsp_data  out  8  captured read data; held until the next read completes
bus_addr  out  8  to tpu addr
bus_wdata  out  8  to tpu data_in
bus_we  out  1  to tpu we
bus_rdata  in  8  from tpu data_out
TPUINT  in  1  interrupt level from the tpu
irq_count  out  8  TPUINT rising edges seen; wraps 255 -> 0
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, bus_addr=0, bus_wdata=0, bus_we=0, irq_count=0, busy=0.
- Reset also empties the FIFO, clears irq_pending and the TPUINT edge register, and forces IDLE. Reset mid-transaction aborts it: no rsp_valid pulse and no further bus_we.
- All outputs are registered.
- FIFO push on cmd_valid && cmd_ready. cmd_ready = !full, so a push is never accepted while full. A pop from full in the same cycle does not allow a push; cmd_ready rises the cycle after the pop.
- TPUINT edge detect: tpuint_q <= TPUINT. A rise is TPUINT && !tpuint_q.
  - Each rise increments irq_count.
  - If IRQ_AUTOCLR=1, each rise also sets irq_pending.
- States: IDLE, WR, RD_WAIT, IRQ_CLR.
- IDLE, checked in priority order:
  - irq_pending=1: load bus_addr=INTFLAG_ADDR, bus_wdata=INTCLR_VALUE, bus_we=1; clear irq_pending; go to IRQ_CLR.
  - FIFO non-empty: pop the head entry.
    - Write: bus_addr/bus_wdata from the entry, bus_we=1, go to WR.
    - Read: bus_addr from the entry, bus_we=0, load the wait counter, go to RD_WAIT.
  - Otherwise stay in IDLE; bus_we=0; bus_addr and bus_wdata keep their last values.
- WR and IRQ_CLR: last exactly one cycle with bus_we=1. On exit, bus_we=0 and the state returns to IDLE, so there is at least one idle cycle between transactions.
- RD_WAIT: bus_addr held, bus_we=0.
  - bus_rdata is sampled at the (RD_LATENCY+1)-th rising edge after bus_addr is first driven.
  - That edge loads rsp_data and sets rsp_valid=1 for exactly one cycle, then the state returns to IDLE.
- Latency from an idle, empty block:
  - Handshake at edge E0; bus_we or a new bus_addr appears after E1.
  - Write: bus_we high between E1 and E2.
  - Read: rsp_valid high after edge E(2+RD_LATENCY).
- Simultaneous events:
  - A TPUINT rise in the same cycle that IDLE clears irq_pending: the set wins, so a second clear write follows.
  - A TPUINT rise during a transaction: the service waits for the current transaction to complete; commands are never pre-empted mid-transaction.
  - With IRQ_AUTOCLR=0, irq_pending stays 0 and only irq_count advances.
- Commands execute in FIFO order. Reads and writes are never reordered relative to each other.

Test Plan:
- Reset, then write cmd (addr=8'h05, wdata=8'hA5) at E0 -> exactly one cycle of bus_we=1 with bus_addr=8'h05, bus_wdata=8'hA5 after E1; busy=0 after E2.
- Read cmd addr=8'h07, model returns 8'h3C with RD_LATENCY=1 -> rsp_valid pulses once after E3 with rsp_data=8'h3C; bus_we stays 0 throughout.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while blocked -> cmd_ready=0 after the 4th push; the 5th is accepted after the first pop; all execute in order, verified against a bus scoreboard.
- TPUINT 0->1 while two writes are queued and a write is in flight -> in-flight write completes, then the clear write (addr 8'h02, data 8'h00), then the queued writes; irq_count=1.
- RST asserted in RD_WAIT -> next cycle bus_we=0, busy=0, cmd_ready=1, irq_count=0; no rsp_valid pulse ever occurs for the aborted read.
- IRQ_AUTOCLR=0, 256 TPUINT pulses -> irq_count wraps to 0; no bus_we asserted.

Source files
------------

// File: rtl/tpu_reg_master.sv
// Register-bus initiator for the TPU register file: host commands are buffered in a FIFO
// and executed one at a time; TPUINT rising edges are counted and optionally auto-cleared.
module tpu_reg_master #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          RD_LATENCY   = 1,
  parameter int          IRQ_AUTOCLR  = 1,
  parameter logic [7:0]  INTFLAG_ADDR = 8'h02,
  parameter logic [7:0]  INTCLR_VALUE = 8'h00
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  input  logic [7:0] bus_rdata,
  input  logic       TPUINT,
  output logic [7:0] irq_count,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam bit AUTOCLR = (IRQ_AUTOCLR != 0);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, IRQ_CLR} state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t          fifo [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, start_irq, to_idle, rise;
  logic          tpuint_q, irq_pending;
  logic [1:0]    wait_cnt;
  state_t        state;

  assign head      = fifo[rd_ptr];
  assign push      = cmd_valid && cmd_ready;
  assign rise      = TPUINT && !tpuint_q;
  // Interrupt service has priority over queued commands, but only from IDLE.
  assign start_irq = (state == IDLE) && irq_pending;
  assign pop       = (state == IDLE) && !irq_pending && (count != '0);
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign to_idle   = ((state == IDLE) && !start_irq && !pop) || (state == WR) ||
                     (state == IRQ_CLR) || ((state == RD_WAIT) && (wait_cnt == 2'd0));

  always_ff @(posedge SYS_CLK) begin
    if (push) fifo[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_we      <= 1'b0;
      irq_count   <= '0;
      busy        <= 1'b0;
      tpuint_q    <= 1'b0;
      irq_pending <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      tpuint_q <= TPUINT;
      if (rise) irq_count <= irq_count + 8'd1;
      // A new edge beats the clear issued in the same cycle, so it gets its own service.
      if (rise && AUTOCLR) irq_pending <= 1'b1;
      else if (start_irq)  irq_pending <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != (AW+1)'(FIFO_DEPTH));
      busy      <= !to_idle || (count_nxt != '0);
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start_irq) begin
            bus_addr  <= INTFLAG_ADDR;
            bus_wdata <= INTCLR_VALUE;
            bus_we    <= 1'b1;
            state     <= IRQ_CLR;
          end else if (pop) begin
            bus_addr <= head.addr;
            if (head.write) begin
              bus_wdata <= head.wdata;
              bus_we    <= 1'b1;
              state     <= WR;
            end else begin
              bus_we   <= 1'b0;
              wait_cnt <= 2'(RD_LATENCY);
              state    <= RD_WAIT;
            end
          end else begin
            bus_we <= 1'b0;
          end
        end
        WR, IRQ_CLR: begin
          bus_we <= 1'b0;
          state  <= IDLE;
        end
        RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_data  <= bus_rdata;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_reg_master.sv
// Directed bench for tpu_reg_master: bus transactions are logged by a monitor and
// checked in order against a scoreboard filled as stimulus is driven.
module tb_tpu_reg_master;

  logic       SYS_CLK = 1'b0;
  logic       RST;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data, bus_addr, bus_wdata, bus_rdata, irq_count;
  logic       bus_we, TPUINT, busy;

  logic       cmd_ready2, rsp_valid2, bus_we2, TPUINT2, busy2;
  logic [7:0] rsp_data2, bus_addr2, bus_wdata2, irq_count2;
  logic [7:0] rdata_q;

  always #5 SYS_CLK = ~SYS_CLK;

  tpu_reg_master #(.FIFO_DEPTH(4), .RD_LATENCY(1), .IRQ_AUTOCLR(1),
                   .INTFLAG_ADDR(8'h02), .INTCLR_VALUE(8'h00)) u_dut (
    .SYS_CLK(SYS_CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
    .TPUINT(TPUINT), .irq_count(irq_count), .busy(busy));

  tpu_reg_master #(.FIFO_DEPTH(4), .RD_LATENCY(1), .IRQ_AUTOCLR(0)) u_dut_nc (
    .SYS_CLK(SYS_CLK), .RST(RST),
    .cmd_valid(1'b0), .cmd_ready(cmd_ready2), .cmd_write(1'b0),
    .cmd_addr(8'h00), .cmd_wdata(8'h00),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_we(bus_we2), .bus_rdata(8'h00),
    .TPUINT(TPUINT2), .irq_count(irq_count2), .busy(busy2));

  // TPU register model: read data = addr ^ 8'h3B, one clock of read latency
  always @(posedge SYS_CLK) rdata_q <= bus_addr ^ 8'h3B;
  assign bus_rdata = rdata_q;

  // Bus monitor: {we, addr, data} per write cycle or per read response
  logic [16:0] bus_log [$];
  int          we2_cnt = 0;
  always @(negedge SYS_CLK) begin
    if (bus_we)         bus_log.push_back({1'b1, bus_addr, bus_wdata});
    else if (rsp_valid) bus_log.push_back({1'b0, bus_addr, rsp_data});
    if (bus_we2) we2_cnt <= we2_cnt + 1;
  end

  int          n_chk = 0, n_fail = 0, li = 0;
  logic [16:0] exp_q [$];
  logic [16:0] pend  [$];
  localparam logic [16:0] CLR = {1'b1, 8'h02, 8'h00};

  task automatic tick();
    @(posedge SYS_CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] expof(input logic [16:0] c);
    return c[16] ? c : {1'b0, c[15:8], c[15:8] ^ 8'h3B};
  endfunction

  task automatic drive(input logic [16:0] c);
    cmd_valid = 1'b1;
    {cmd_write, cmd_addr, cmd_wdata} = c;
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [16:0] e;
    repeat (16) tick();
    chk({tag, "_count"}, 32'(bus_log.size() - li), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (li < bus_log.size()) begin
        chk(tag, 32'(bus_log[li]), 32'(e));
        li++;
      end
    end
    li = bus_log.size();
  endtask

  logic [16:0] c3 [5];
  int          k;
  logic        acc;

  initial begin
    RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    TPUINT = 1'b0; TPUINT2 = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_irq_count", irq_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq_count_nc", irq_count2, 0);
    RST = 1'b0;
    tick();

    // single write
    drive({1'b1, 8'h05, 8'hA5}); exp_q.push_back({1'b1, 8'h05, 8'hA5});
    tick();                                   // E0
    cmd_valid = 1'b0;
    chk("wr_e0_we", bus_we, 0);
    chk("wr_e0_busy", busy, 1);
    tick();                                   // E1
    chk("wr_e1_we", bus_we, 1);
    chk("wr_e1_addr", bus_addr, 8'h05);
    chk("wr_e1_wdata", bus_wdata, 8'hA5);
    tick();                                   // E2
    chk("wr_e2_we", bus_we, 0);
    chk("wr_e2_busy", busy, 0);
    drain("wr_sb");

    // single read, latency 1
    drive({1'b0, 8'h07, 8'h00}); exp_q.push_back({1'b0, 8'h07, 8'h3C});
    tick();                                   // E0
    cmd_valid = 1'b0;
    tick();                                   // E1
    chk("rd_e1_addr", bus_addr, 8'h07);
    chk("rd_e1_rsp", rsp_valid, 0);
    tick();                                   // E2
    chk("rd_e2_rsp", rsp_valid, 0);
    tick();                                   // E3
    chk("rd_e3_rsp", rsp_valid, 1);
    chk("rd_e3_data", rsp_data, 8'h3C);
    tick();
    chk("rd_e4_rsp", rsp_valid, 0);
    chk("rd_e4_hold", rsp_data, 8'h3C);
    drain("rd_sb");                           // also catches any bus_we during the read

    // FIFO full: TPUINT toggling keeps the block in interrupt service
    c3[0] = {1'b1, 8'h10, 8'h01}; c3[1] = {1'b0, 8'h11, 8'h00}; c3[2] = {1'b1, 8'h12, 8'h03};
    c3[3] = {1'b1, 8'h13, 8'h04}; c3[4] = {1'b0, 8'h14, 8'h00};
    k = 0;
    for (int i = 0; i < 10; i++) begin
      TPUINT = (i % 2 == 0);
      if (i % 2 == 0) exp_q.push_back(CLR);
      if (i >= 2 && k < 5) drive(c3[k]); else cmd_valid = 1'b0;
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) begin
        pend.push_back(expof(c3[k]));
        k++;
        if (k == 4) chk("full_after_4", cmd_ready, 0);
      end
    end
    chk("full_held", cmd_ready, 0);
    chk("full_pushes", k, 4);
    TPUINT = 1'b0;
    for (int t = 0; t < 40 && k < 5; t++) begin
      drive(c3[k]);
      acc = cmd_ready;
      tick();
      if (acc) begin pend.push_back(expof(c3[k])); k++; end
    end
    cmd_valid = 1'b0;
    chk("fifth_accepted", k, 5);
    while (pend.size() > 0) exp_q.push_back(pend.pop_front());
    drain("order_sb");
    chk("irq_count_5", irq_count, 5);

    // TPUINT rise while a write is in flight and two writes are queued
    do_reset();
    drive({1'b1, 8'h20, 8'h11}); exp_q.push_back({1'b1, 8'h20, 8'h11});
    tick();                                   // E0
    drive({1'b1, 8'h21, 8'h22});
    exp_q.push_back(CLR); exp_q.push_back({1'b1, 8'h21, 8'h22});
    tick();                                   // E1: first write on the bus
    drive({1'b1, 8'h22, 8'h33}); exp_q.push_back({1'b1, 8'h22, 8'h33});
    TPUINT = 1'b1;
    tick();                                   // E2
    cmd_valid = 1'b0;
    repeat (3) tick();
    TPUINT = 1'b0;
    drain("irq_sb");
    chk("irq_count_1", irq_count, 1);

    // rise coincides with the clear issued from IDLE: two clears follow the read
    drive({1'b0, 8'h40, 8'h00});
    exp_q.push_back(expof({1'b0, 8'h40, 8'h00})); exp_q.push_back(CLR); exp_q.push_back(CLR);
    tick();                                   // E0
    cmd_valid = 1'b0;
    tick();                                   // E1
    TPUINT = 1'b1; tick();                    // E2: rise during RD_WAIT
    TPUINT = 1'b0; tick();                    // E3: read completes
    TPUINT = 1'b1; tick();                    // E4: IDLE clears while a new rise arrives
    TPUINT = 1'b0;
    drain("irq_same_sb");
    chk("irq_count_3", irq_count, 3);

    // reset during RD_WAIT aborts the read
    drive({1'b0, 8'h30, 8'h00});
    tick();                                   // E0
    cmd_valid = 1'b0;
    tick();                                   // E1
    chk("abort_pre_rsp", rsp_valid, 0);
    RST = 1'b1;
    tick();
    chk("abort_we", bus_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_irq_count", irq_count, 0);
    chk("abort_rsp", rsp_valid, 0);
    RST = 1'b0;
    drain("abort_sb");

    // IRQ_AUTOCLR=0: count only, wraps after 256 edges
    for (int p = 0; p < 256; p++) begin
      TPUINT2 = 1'b1; tick();
      TPUINT2 = 1'b0; tick();
      if (p == 254) chk("nc_count_255", irq_count2, 255);
    end
    chk("nc_count_wrap", irq_count2, 0);
    chk("nc_no_we", we2_cnt, 0);
    chk("nc_busy", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
